pulse_train_gen: RTL and testbench
==================================

PULSE_TRAIN_GEN -- requirements
Module: pulse_train_gen

Interface
REQ-001 The block SHALL have parameter COUNT_BITS, default 16: width of the pulse-count request and the sent-pulse counter.
REQ-002 The block SHALL have parameter PERIOD_BITS, default 16: width of the half-period request, in clk_en ticks.
REQ-003 Port clk  input  1  system clock; the block SHALL use this single clock.
REQ-004 Port reset  input  1  synchronous, active-low reset, sampled on posedge clk.
REQ-005 Port clk_en  input  1  slow tick; all state changes except reset SHALL occur only on cycles with clk_en=1.
REQ-006 Port start  input  1  request to begin a train, sampled on a tick.
REQ-007 Port stop  input  1  request to abort a train, sampled on a tick.
REQ-008 Port num_pulses  input  COUNT_BITS  number of pulses requested.
REQ-009 Port half_period  input  PERIOD_BITS  high time and low time per pulse, in ticks.
REQ-010 Port pulse_out  output  1  step pulse, registered.
REQ-011 Port busy  output  1  high while in HIGH or LOW state.
REQ-012 Port done  output  1  high while in DONE state.
REQ-013 Port pulses_sent  output  COUNT_BITS  count of completed pulses in the current or last train.

Function
REQ-014 The block SHALL implement states IDLE, HIGH, LOW and DONE; outputs SHALL derive from registers only.
REQ-015 In IDLE, a tick with start=1 and stop=0 SHALL latch num_pulses (N) and half_period (H), clear pulses_sent and phase counter, and enter HIGH with pulse_out=1, or enter DONE if N=0.
REQ-016 H=0 SHALL be treated as H=1.
REQ-017 In HIGH, each tick SHALL increment the phase counter; the tick on which the phase reaches H SHALL set pulse_out=0, reset the phase counter and enter LOW.
REQ-018 In LOW, the tick on which the phase reaches H SHALL increment pulses_sent, then enter DONE if the new count equals N, otherwise re-enter HIGH with pulse_out=1.
REQ-019 pulse_out SHALL be high for exactly H ticks and low for exactly H ticks per pulse; a full train SHALL span 2*N*H ticks from the start tick to entering DONE.
REQ-020 DONE SHALL last exactly one tick, then return to IDLE; pulses_sent SHALL hold its value until the next accepted start.
REQ-021 start while in HIGH, LOW or DONE SHALL be ignored; num_pulses and half_period changes after latching SHALL have no effect.
REQ-022 A tick with stop=1 in HIGH or LOW SHALL force pulse_out=0 and enter DONE; pulses_sent SHALL keep its completed-pulse count and SHALL NOT count a partial pulse.
REQ-023 stop=1 with start=1 in IDLE SHALL leave the block in IDLE; stop in DONE or IDLE SHALL have no effect.
REQ-024 Counters SHALL NOT wrap: N=2^COUNT_BITS-1 SHALL complete normally, and H=2^PERIOD_BITS-1 SHALL give exactly that many ticks per phase.
REQ-025 With clk_en=0, every register SHALL hold its value.

Reset
REQ-026 reset=0 at posedge clk SHALL, regardless of clk_en, set the state to IDLE and set pulse_out=0, busy=0, done=0, pulses_sent=0 and the phase counter to 0.
REQ-027 reset asserted mid-train SHALL abort without asserting done; the first tick after reset is released SHALL accept start.

Verification
REQ-028 clk_en every cycle, N=3, H=2, start pulse -> pulse_out sequence 1,1,0,0 repeated 3 times; done high on the 13th tick after start; pulses_sent=3; busy high for 12 ticks.
REQ-029 clk_en every 4th cycle, N=2, H=1 -> pulse_out changes only on clk_en cycles; train spans 4 ticks (16 clks); done lasts 4 clks.
REQ-030 N=0, H=5, start -> done on the next tick; pulse_out stays 0; pulses_sent=0.
REQ-031 N=4, H=3; stop during the 2nd pulse high phase -> pulse_out=0 next tick; done for one tick; pulses_sent=1; a new start with N=1, H=0 then yields a single 1-tick-high, 1-tick-low pulse.
REQ-032 start held high through an N=2, H=1 train, with num_pulses changed to 7 mid-train -> exactly 2 pulses; a second train starts on the tick after DONE.
REQ-033 reset=0 during LOW of a train with N=5, H=2 -> next cycle pulse_out=0, busy=0, done=0, pulses_sent=0; no done pulse is seen.

Source files
------------

// File: rtl/pulse_train_gen.sv
// Pulse train generator: emits N step pulses of H ticks high / H ticks low,
// advancing only on clk_en ticks, with abort (stop) and completion reporting.
//
// state  | meaning
// -------+----------------------------------------------------------
// S_IDLE | waiting for start; pulses_sent holds the last train's count
// S_HIGH | pulse_out high, counting phase ticks up to H
// S_LOW  | pulse_out low, counting phase ticks; pulse completes at H
// S_DONE | one-tick completion/abort indication, then back to idle
module pulse_train_gen #(
  parameter int COUNT_BITS  = 16,
  parameter int PERIOD_BITS = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   clk_en,
  input  logic                   start,
  input  logic                   stop,
  input  logic [COUNT_BITS-1:0]  num_pulses,
  input  logic [PERIOD_BITS-1:0] half_period,
  output logic                   pulse_out,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_BITS-1:0]  pulses_sent
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t                 r_state;
  logic [COUNT_BITS-1:0]  r_n;
  logic [PERIOD_BITS-1:0] r_h;
  logic [PERIOD_BITS-1:0] r_phase;
  logic [COUNT_BITS-1:0]  r_count;
  logic                   r_pulse_out;
  logic                   r_busy;
  logic                   r_done;

  logic [PERIOD_BITS-1:0] w_phase_next;
  logic                   w_phase_done;
  logic [COUNT_BITS-1:0]  w_count_next;
  logic                   w_last_pulse;
  logic [PERIOD_BITS-1:0] w_h_eff;

  // The phase counter only ever reaches H-1 before being compared, so the
  // increment cannot overflow even when H is the maximum representable value.
  assign w_phase_next = r_phase + PERIOD_BITS'(1);
  assign w_phase_done = (w_phase_next == r_h);
  assign w_count_next = r_count + COUNT_BITS'(1);
  assign w_last_pulse = (w_count_next == r_n);
  // A zero half-period would never terminate a phase, so it runs as one tick.
  assign w_h_eff      = (half_period == '0) ? PERIOD_BITS'(1) : half_period;

  // Sequencer: all state and outputs are registered and advance on ticks only.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state     <= S_IDLE;
      r_n         <= '0;
      r_h         <= '0;
      r_phase     <= '0;
      r_count     <= '0;
      r_pulse_out <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
    end else if (clk_en) begin
      unique case (r_state)
        S_IDLE: begin
          if (start && !stop) begin
            r_n     <= num_pulses;
            r_h     <= w_h_eff;
            r_phase <= '0;
            r_count <= '0;
            if (num_pulses == '0) begin
              r_state <= S_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_HIGH;
              r_pulse_out <= 1'b1;
              r_busy      <= 1'b1;
            end
          end
        end
        S_HIGH: begin
          if (stop) begin
            r_state     <= S_DONE;
            r_phase     <= '0;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_phase_done) begin
            r_state     <= S_LOW;
            r_phase     <= '0;
            r_pulse_out <= 1'b0;
          end else begin
            r_phase <= w_phase_next;
          end
        end
        S_LOW: begin
          // Abort takes priority, so an interrupted pulse is never counted.
          if (stop) begin
            r_state     <= S_DONE;
            r_phase     <= '0;
            r_pulse_out <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b1;
          end else if (w_phase_done) begin
            r_phase <= '0;
            r_count <= w_count_next;
            if (w_last_pulse) begin
              r_state <= S_DONE;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end else begin
              r_state     <= S_HIGH;
              r_pulse_out <= 1'b1;
            end
          end else begin
            r_phase <= w_phase_next;
          end
        end
        S_DONE: begin
          r_state <= S_IDLE;
          r_done  <= 1'b0;
        end
        default: begin
          r_state     <= S_IDLE;
          r_pulse_out <= 1'b0;
          r_busy      <= 1'b0;
          r_done      <= 1'b0;
        end
      endcase
    end
  end

  assign pulse_out   = r_pulse_out;
  assign busy        = r_busy;
  assign done        = r_done;
  assign pulses_sent = r_count;

endmodule

// File: tb/tb_pulse_train_gen.sv
// Scoreboard bench for pulse_train_gen: the stimulus side pushes the expected
// output state for every clock it issues; the monitor pops and compares on
// the following falling edge.
module tb_pulse_train_gen;

  localparam int CB = 4;
  localparam int PB = 4;

  logic          clk;
  logic          rst_n;
  logic          clk_en;
  logic          start;
  logic          stop;
  logic [CB-1:0] num_pulses;
  logic [PB-1:0] half_period;
  logic          pulse_out;
  logic          busy;
  logic          done;
  logic [CB-1:0] pulses_sent;

  pulse_train_gen #(.COUNT_BITS(CB), .PERIOD_BITS(PB)) dut (
    .clk         (clk),
    .reset       (rst_n),
    .clk_en      (clk_en),
    .start       (start),
    .stop        (stop),
    .num_pulses  (num_pulses),
    .half_period (half_period),
    .pulse_out   (pulse_out),
    .busy        (busy),
    .done        (done),
    .pulses_sent (pulses_sent)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic          q_po[$];
  logic          q_bz[$];
  logic          q_dn[$];
  logic [CB-1:0] q_ps[$];
  string         q_nm[$];

  int  n_checks;
  int  n_fail;
  bit  stim_done;

  // One clock: drive inputs, record the expected outputs after the next edge.
  task automatic cyc(input logic e, input logic s, input logic p,
                     input logic po, input logic bz, input logic dn,
                     input int ps, input string nm);
    logic [31:0] psv;
    psv     = ps;
    clk_en  = e;
    start   = s;
    stop    = p;
    q_po.push_back(po);
    q_bz.push_back(bz);
    q_dn.push_back(dn);
    q_ps.push_back(psv[CB-1:0]);
    q_nm.push_back(nm);
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  // One tick followed by 'gap' idle clocks over which everything must hold.
  task automatic tick(input logic s, input logic p,
                      input logic po, input logic bz, input logic dn,
                      input int ps, input string nm, input int gap);
    cyc(1'b1, s, p, po, bz, dn, ps, nm);
    for (int g = 0; g < gap; g++) cyc(1'b0, s, p, po, bz, dn, ps, {nm, "_hold"});
  endtask

  // Remainder of a train after its start tick: H high, H low per pulse,
  // one DONE tick, then the return to idle.
  task automatic run_train(input int n, input int h, input logic s,
                           input int gap, input string nm);
    for (int p = 0; p < n; p++) begin
      for (int k = 1; k < h; k++) tick(s, 1'b0, 1'b1, 1'b1, 1'b0, p, {nm, "_high"}, gap);
      tick(s, 1'b0, 1'b0, 1'b1, 1'b0, p, {nm, "_fall"}, gap);
      for (int k = 1; k < h; k++) tick(s, 1'b0, 1'b0, 1'b1, 1'b0, p, {nm, "_low"}, gap);
      if (p == n - 1) tick(s, 1'b0, 1'b0, 1'b0, 1'b1, p + 1, {nm, "_done"}, gap);
      else            tick(s, 1'b0, 1'b1, 1'b1, 1'b0, p + 1, {nm, "_rise"}, gap);
    end
    tick(s, 1'b0, 1'b0, 1'b0, 1'b0, n, {nm, "_idle"}, gap);
  endtask

  // Monitor: compares the DUT outputs against the oldest expectation.
  initial begin
    n_checks = 0;
    n_fail   = 0;
    while (!stim_done) begin
      @(negedge clk);
      if (q_po.size() > 0) begin
        logic          e_po, e_bz, e_dn;
        logic [CB-1:0] e_ps;
        string         e_nm;
        e_po = q_po.pop_front();
        e_bz = q_bz.pop_front();
        e_dn = q_dn.pop_front();
        e_ps = q_ps.pop_front();
        e_nm = q_nm.pop_front();
        n_checks++;
        if (pulse_out !== e_po || busy !== e_bz || done !== e_dn || pulses_sent !== e_ps) begin
          n_fail++;
          $display("FAIL %s: got pulse_out=%0b busy=%0b done=%0b pulses_sent=%0d, expected pulse_out=%0b busy=%0b done=%0b pulses_sent=%0d",
                   e_nm, pulse_out, busy, done, pulses_sent, e_po, e_bz, e_dn, e_ps);
        end
      end
    end
    n_checks++;
    if (q_po.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, expected 0", q_po.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Stimulus: directed scenarios.
  initial begin
    stim_done   = 1'b0;
    rst_n       = 1'b0;
    clk_en      = 1'b0;
    start       = 1'b0;
    stop        = 1'b0;
    num_pulses  = '0;
    half_period = '0;
    @(negedge clk);
    #1;

    // Reset applies with or without a tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_no_en");
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "reset_with_en");
    rst_n = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0, "idle_no_tick");

    // N=3, H=2, tick every clock.
    num_pulses = 4'd3; half_period = 4'd2;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "a_start", 0);
    run_train(3, 2, 1'b0, 0, "a");

    // N=2, H=1, tick every 4th clock: nothing moves between ticks.
    num_pulses = 4'd2; half_period = 4'd1;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "b_start", 3);
    run_train(2, 1, 1'b0, 3, "b");

    // N=0: straight to DONE, count cleared.
    num_pulses = 4'd0; half_period = 4'd5;
    tick(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 0, "c_done", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "c_idle", 0);

    // N=4, H=3, stop during the second pulse's high phase.
    num_pulses = 4'd4; half_period = 4'd3;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "d_start", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, "d_high", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, "d_high", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "d_fall", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "d_low", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "d_low", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "d_rise2", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "d_high2", 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, "d_stop", 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "d_stop_in_done", 0);
    tick(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, "d_stop_in_idle", 0);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1, "d_start_and_stop", 0);
    num_pulses = 4'd1; half_period = 4'd0;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "d_h0_start", 0);
    run_train(1, 1, 1'b0, 0, "d_h0");

    // Start held through the train, inputs changed after latching.
    num_pulses = 4'd2; half_period = 4'd1;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "e_start", 0);
    num_pulses = 4'd7; half_period = 4'd3;
    run_train(2, 1, 1'b1, 0, "e");
    num_pulses = 4'd1; half_period = 4'd1;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "e_restart", 0);
    run_train(1, 1, 1'b0, 0, "e2");

    // N=5, H=2, reset during the second pulse's low phase.
    num_pulses = 4'd5; half_period = 4'd2;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "f_start", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 0, "f_high", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "f_fall", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 0, "f_low", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "f_rise2", 0);
    tick(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1, "f_high2", 0);
    tick(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1, "f_fall2", 0);
    rst_n = 1'b0;
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "f_reset");
    rst_n = 1'b1;
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0, "f_after_reset");
    num_pulses = 4'd1; half_period = 4'd1;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "f_restart", 0);
    run_train(1, 1, 1'b0, 0, "f2");

    // Maximum count and maximum half-period.
    num_pulses = 4'd15; half_period = 4'd15;
    tick(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 0, "g_start", 0);
    run_train(15, 15, 1'b0, 0, "g");

    stim_done = 1'b1;
  end

endmodule
